// File: rtl/slicer_err_gen_pkg.sv
// Shared definitions for the slicer error generator.
//
// Holds the window length parameter and the FSM state encodings used by
// slicer_err_gen. It also holds the Gray-coded decision values and the
// helper that saturates a 20-bit intermediate value to the 18-bit 1s17
// range. Both slicer_err_gen and slicer_4ask use these definitions.
package slicer_err_gen_pkg;

  // The measurement window is 2^LFSR_LEN symbols long.
  localparam int LFSR_LEN = 4;

  // Width of the internal arithmetic. It holds +/-3b and sample - level
  // without overflow.
  localparam int WIDE_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Gray-coded symbol decisions. Adjacent levels differ in one bit.
  localparam logic [1:0] DEC_NEG3 = 2'b00;
  localparam logic [1:0] DEC_NEG1 = 2'b01;
  localparam logic [1:0] DEC_POS1 = 2'b11;
  localparam logic [1:0] DEC_POS3 = 2'b10;

  // Clamp a 20-bit signed value into 18-bit signed.
  // The value fits when its top three bits all equal the sign bit.
  function automatic logic signed [17:0] sat18(input logic signed [WIDE_W-1:0] v);
    logic signed [17:0] r;
    if (v[WIDE_W-1:17] != {3{v[WIDE_W-1]}}) begin
      r = v[WIDE_W-1] ? 18'sh20000 : 18'sh1FFFF;
    end else begin
      r = v[17:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/slicer_4ask.sv
// Combinational 4-level slicer.
//
// Takes one received symbol and the inner level b. It picks the nearest of
// -3b, -b, +b and +3b using the thresholds -2b, 0 and +2b. It returns the
// Gray decision and the saturated error (sample minus chosen level).
//
// Ports:
//   sample    in  18 signed 1s17  symbol to slice
//   ref_level in  18 signed 1s17  inner level b
//   err       out 18 signed 1s17  sample - level, saturated
//   decision  out 2               Gray symbol code
module slicer_4ask
  import slicer_err_gen_pkg::*;
(
  input  logic signed [17:0] sample,
  input  logic signed [17:0] ref_level,
  output logic signed [17:0] err,
  output logic        [1:0]  decision
);

  logic signed [WIDE_W-1:0] s_w;
  logic signed [WIDE_W-1:0] b_w;
  logic signed [WIDE_W-1:0] thr_w;
  logic signed [WIDE_W-1:0] level_w;
  logic signed [WIDE_W-1:0] diff_w;

  // Widen first so that 2b, 3b and the difference cannot wrap.
  // The outer level 3b is built as b + 2b, which reuses the threshold value.
  always_comb begin
    s_w   = {{(WIDE_W-18){sample[17]}}, sample};
    b_w   = {{(WIDE_W-18){ref_level[17]}}, ref_level};
    thr_w = b_w <<< 1;
    if (s_w >= thr_w) begin
      level_w  = b_w + thr_w;
      decision = DEC_POS3;
    end else if (!s_w[WIDE_W-1]) begin
      level_w  = b_w;
      decision = DEC_POS1;
    end else if (s_w >= -thr_w) begin
      level_w  = -b_w;
      decision = DEC_NEG1;
    end else begin
      level_w  = -(b_w + thr_w);
      decision = DEC_NEG3;
    end
    diff_w = s_w - level_w;
    err    = sat18(diff_w);
  end

endmodule

// File: rtl/slicer_err_gen.sv
// Slicer error generator with a measurement-window sequencer.
//
// The datapath has two stages. A symbol is registered on one strobe and
// then sliced. Its error and decision are registered on the next strobe.
// This datapath always runs. The window FSM gives the first two strobes
// after enable to pipeline fill. It then counts symbols through a window of
// 2^LFSR_LEN. It pulses hold on the strobe that ends each window.
//
// Ports:
//   clk       in  1             system clock, rising edge
//   reset     in  1             asynchronous reset, active low
//   clk_en    in  1             one-clk symbol strobe
//   meas_en   in  1             level, enables the measurement window
//   sample    in  18 signed     received symbol, valid on clk_en
//   ref_level in  18 signed     inner level b, quasi-static
//   err       out 18 signed     registered slicer error
//   decision  out 2             registered Gray decision
//   hold      out 1             window-end pulse, coincident with clk_en
//   win_cnt   out LFSR_LEN      symbol index within the window
module slicer_err_gen
  import slicer_err_gen_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 meas_en,
  input  logic signed [17:0]   sample,
  input  logic signed [17:0]   ref_level,
  output logic signed [17:0]   err,
  output logic        [1:0]    decision,
  output logic                 hold,
  output logic [LFSR_LEN-1:0]  win_cnt
);

  localparam logic [LFSR_LEN-1:0] WIN_LAST = '1;

  logic signed [17:0]   sample_q, sample_d;
  logic signed [17:0]   err_q, err_d;
  logic        [1:0]    decision_q, decision_d;
  state_e               state_q, state_d;
  logic [LFSR_LEN-1:0]  win_cnt_q, win_cnt_d;
  logic                 prime_cnt_q, prime_cnt_d;

  logic signed [17:0]   slice_err;
  logic        [1:0]    slice_dec;

  slicer_4ask u_slicer (
    .sample    (sample_q),
    .ref_level (ref_level),
    .err       (slice_err),
    .decision  (slice_dec)
  );

  // Both pipeline stages advance only on a strobe. The FSM state does not
  // affect them.
  always_comb begin
    sample_d   = sample_q;
    err_d      = err_q;
    decision_d = decision_q;
    if (clk_en) begin
      sample_d   = sample;
      err_d      = slice_err;
      decision_d = slice_dec;
    end
  end

  // Window sequencer. Dropping meas_en wins over everything else. This also
  // blocks a hold on the same clock, because hold is only produced in the
  // RUN branch. PRIME uses a one-bit counter to let two strobes pass, which
  // fills the pipeline. The window counter wraps by its natural width.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    prime_cnt_d = prime_cnt_q;
    hold        = 1'b0;
    if (!meas_en) begin
      state_d     = ST_IDLE;
      win_cnt_d   = '0;
      prime_cnt_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_PRIME;
          win_cnt_d   = '0;
          prime_cnt_d = 1'b0;
        end
        ST_PRIME: begin
          if (clk_en) begin
            if (prime_cnt_q) begin
              state_d     = ST_RUN;
              win_cnt_d   = '0;
              prime_cnt_d = 1'b0;
            end else begin
              prime_cnt_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (clk_en) begin
            win_cnt_d = win_cnt_q + 1'b1;
            hold      = (win_cnt_q == WIN_LAST);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          win_cnt_d = '0;
        end
      endcase
    end
  end

  // Reset clears the whole pipeline and the sequencer. After release the
  // block goes through IDLE and PRIME again, so no partial window produces
  // a hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q    <= '0;
      err_q       <= '0;
      decision_q  <= DEC_NEG3;
      state_q     <= ST_IDLE;
      win_cnt_q   <= '0;
      prime_cnt_q <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      err_q       <= err_d;
      decision_q  <= decision_d;
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign err      = err_q;
  assign decision = decision_q;
  assign win_cnt  = win_cnt_q;

endmodule
